// File: rtl/abram_aging_arbiter_mux_pkg.sv
// Shared defaults and helpers for the ABRAM aging arbiter mux.
// Optional statistics are enabled with ABRAM_ARB_STATS_EN.
package abram_pkg;
  localparam int INPUTS_DEF = 4;
  localparam int ADDR_DEF   = 32;
  localparam int DATA_DEF   = 64;
  localparam int DEPTH_DEF  = 4;
  localparam int AGE_DEF    = 8;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/abram_aging_arbiter_mux_if.sv
// Request/response bundle between ABRAM producers, the mux and the port.
// Optional statistics are enabled with ABRAM_ARB_STATS_EN.
interface abram_aging_arbiter_mux_if
  import abram_pkg::*;
#(
  parameter int INPUTS    = INPUTS_DEF,
  parameter int ADDR_SIZE = ADDR_DEF,
  parameter int DATA_SIZE = DATA_DEF
);
  logic [INPUTS-1:0]                in_ad_valid;
  logic [INPUTS-1:0][ADDR_SIZE-1:0] in_ad_addr;
  logic [INPUTS-1:0][DATA_SIZE-1:0] in_ad_data;
  logic [INPUTS-1:0]                in_ad_done;
  logic                             out_ad_valid;
  logic [ADDR_SIZE-1:0]             out_ad_addr;
  logic [DATA_SIZE-1:0]             out_ad_data;
  logic                             out_ad_done;

  modport master (
    output in_ad_valid, in_ad_addr, in_ad_data, out_ad_done,
    input  in_ad_done, out_ad_valid, out_ad_addr, out_ad_data
  );

  modport slave (
    input  in_ad_valid, in_ad_addr, in_ad_data, out_ad_done,
    output in_ad_done, out_ad_valid, out_ad_addr, out_ad_data
  );
endinterface

// File: rtl/abram_aging_arbiter_mux_req_fifo.sv
// Per-input request FIFO; full/empty derive only from registered pointers.
// Optional statistics are enabled with ABRAM_ARB_STATS_EN.
module abram_req_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/abram_aging_arbiter_mux.sv
// N:1 ABRAM request mux: per-input FIFOs, saturating age arbitration, registered output.
// Optional per-input grant counters are enabled with ABRAM_ARB_STATS_EN.
module abram_aging_arbiter_mux
  import abram_pkg::*;
#(
  parameter int INPUTS    = INPUTS_DEF,
  parameter int ADDR_SIZE = ADDR_DEF,
  parameter int DATA_SIZE = DATA_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AGE_WIDTH = AGE_DEF
) (
  input  logic clock,
  input  logic reset,
  abram_aging_arbiter_mux_if.slave bus
`ifdef ABRAM_ARB_STATS_EN
  ,
  input  logic                    stats_clear,
  output logic [INPUTS-1:0][31:0] grant_count
`endif
);
  localparam int SEL_W = sel_width(INPUTS);
  localparam int W     = ADDR_SIZE + DATA_SIZE;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [INPUTS-1:0]                full, empty, pop;
  logic [INPUTS-1:0][W-1:0]         head;
  logic [INPUTS-1:0][AGE_WIDTH-1:0] age_q, age_d;
  logic [SEL_W-1:0]                 sel;
  logic                             any_ne, load;
  logic                             out_valid_q, out_valid_d;
  logic [ADDR_SIZE-1:0]             out_addr_q, out_addr_d;
  logic [DATA_SIZE-1:0]             out_data_q, out_data_d;

  // Accepts are masked during reset so nothing is pushed into a cleared FIFO.
  assign bus.in_ad_done = bus.in_ad_valid & ~full & {INPUTS{reset}};

  for (genvar g = 0; g < INPUTS; g++) begin : g_fifo
    abram_req_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clock),
      .rst_n (reset),
      .push  (bus.in_ad_done[g]),
      .pop   (pop[g]),
      .din   ({bus.in_ad_addr[g], bus.in_ad_data[g]}),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  if (INPUTS == 1) begin : g_one
    assign sel = '0;
  end else begin : g_arb
    always_comb begin
      logic [AGE_WIDTH-1:0] best;
      logic                 found;
      sel   = '0;
      best  = '0;
      found = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
        if (!empty[i] && (!found || age_q[i] > best)) begin
          sel   = SEL_W'(i);
          best  = age_q[i];
          found = 1'b1;
        end
      end
    end
  end

  assign any_ne = ~&empty;
  assign load   = (~out_valid_q | bus.out_ad_done) & any_ne;

  always_comb begin
    pop         = '0;
    age_d       = age_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < INPUTS; i++) begin
      pop[i] = load && (int'(sel) == i);
      if (empty[i] || pop[i])
        age_d[i] = '0;
      else if (age_q[i] != AGE_MAX)
        age_d[i] = age_q[i] + 1'b1;
    end
    if (load) begin
      out_valid_d              = 1'b1;
      {out_addr_d, out_data_d} = head[sel];
    end else if (bus.out_ad_done) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      age_q       <= age_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_ad_valid = out_valid_q;
  assign bus.out_ad_addr  = out_addr_q;
  assign bus.out_ad_data  = out_data_q;

`ifdef ABRAM_ARB_STATS_EN
  logic [INPUTS-1:0][31:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < INPUTS; i++) begin
      if (stats_clear) gcnt_d[i] = '0;
      else if (pop[i]) gcnt_d[i] = gcnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign grant_count = gcnt_q;
`endif
endmodule

// File: tb/tb_abram_aging_arbiter_mux.sv
// Bench for abram_aging_arbiter_mux: vector table, directed corner sequences, beat scoreboard.
// Define ABRAM_ARB_STATS_EN to also exercise the grant counters.
module tb_abram_aging_arbiter_mux;
  localparam int N  = 4;
  localparam int AS = 32;
  localparam int DS = 64;

  typedef struct {
    int          src;
    logic [95:0] beat;
  } sb_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_done;
    int         n;
    int         order [4];
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   tag;
  sb_t  sb [$];
  int   log_q [$];
  vec_t vecs [5];

  abram_aging_arbiter_mux_if #(.INPUTS(N), .ADDR_SIZE(AS), .DATA_SIZE(DS)) bus ();

`ifdef ABRAM_ARB_STATS_EN
  logic              stats_clear;
  logic [N-1:0][31:0] grant_count;
`endif

  abram_aging_arbiter_mux #(
    .INPUTS(N), .ADDR_SIZE(AS), .DATA_SIZE(DS), .DEPTH(4), .AGE_WIDTH(8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef ABRAM_ARB_STATS_EN
    ,
    .stats_clear (stats_clear),
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_addr(input int i, input int t);
    return 32'hA000_0000 | (32'(i) << 16) | (32'(t) & 32'h0000_FFFF);
  endfunction

  function automatic logic [63:0] mk_data(input int i, input int t);
    return {32'hD000_0000 | 32'(i), 32'(t)};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask);
    for (int i = 0; i < N; i++) begin
      bus.in_ad_valid[i] = mask[i];
      bus.in_ad_addr[i]  = mk_addr(i, tag);
      bus.in_ad_data[i]  = mk_data(i, tag);
    end
    tag++;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_ad_valid) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.out_ad_valid) begin
      errors++;
      $display("FAIL drain: %0d beats left after %0d cycles, required 0", sb.size(), budget);
    end
  endtask

  function automatic int log_at(input int k);
    return (k < log_q.size()) ? log_q[k] : -1;
  endfunction

  // Scoreboard: accepted inputs are queued, output beats are matched in per-input order.
  always @(negedge clk) begin
    logic [95:0] beat;
    int          fk;
    bit          bad;
    if (rst_n) begin
      if (bus.out_ad_valid && bus.out_ad_done) begin
        beat = {bus.out_ad_addr, bus.out_ad_data};
        fk   = -1;
        bad  = 1'b0;
        for (int k = 0; k < sb.size(); k++)
          if (fk < 0 && sb[k].beat == beat) fk = k;
        checks++;
        if (fk < 0) begin
          errors++;
          $display("FAIL beat: got unexpected %h, required a queued beat", beat);
        end else begin
          for (int k = 0; k < fk; k++)
            if (sb[k].src == sb[fk].src) bad = 1'b1;
          if (bad) begin
            errors++;
            $display("FAIL order: got %h ahead of older input %0d entry, required FIFO order",
                     beat, sb[fk].src);
          end
          log_q.push_back(sb[fk].src);
          sb.delete(fk);
        end
      end
      for (int i = 0; i < N; i++)
        if (bus.in_ad_done[i])
          sb.push_back('{i, {bus.in_ad_addr[i], bus.in_ad_data[i]}});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int acc;
    checks = 0;
    errors = 0;
    tag    = 1;
    vecs[0] = '{4'b0011, 4'b0011, 2, '{0, 1, 0, 0}};
    vecs[1] = '{4'b1111, 4'b1111, 4, '{0, 1, 2, 3}};
    vecs[2] = '{4'b1010, 4'b1010, 2, '{1, 3, 0, 0}};
    vecs[3] = '{4'b1001, 4'b1001, 2, '{0, 3, 0, 0}};
    vecs[4] = '{4'b0100, 4'b0100, 1, '{2, 0, 0, 0}};
`ifdef ABRAM_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    rst_n = 1'b0;
    bus.out_ad_done = 1'b0;
    drive(4'b1111);
    tick();
    tick();
    chk("rst_done", bus.in_ad_done, 4'b0000);
    chk("rst_valid", bus.out_ad_valid, 1'b0);
    chk("rst_addr", bus.out_ad_addr, 32'h0);
    chk("rst_data", bus.out_ad_data, 64'h0);
    drive(4'b0000);
    rst_n = 1'b1;
    bus.out_ad_done = 1'b1;
    tick();

    // single push on input 2, latency and one-beat pulse
    bus.in_ad_valid = 4'b0100;
    bus.in_ad_addr[2] = 32'h100;
    bus.in_ad_data[2] = 64'hAA;
    #1;
    chk("t1_done", bus.in_ad_done, 4'b0100);
    tick();
    drive(4'b0000);
    chk("t1_v0", bus.out_ad_valid, 1'b0);
    tick();
    chk("t1_v1", bus.out_ad_valid, 1'b1);
    chk("t1_addr", bus.out_ad_addr, 32'h100);
    chk("t1_data", bus.out_ad_data, 64'hAA);
    tick();
    chk("t1_v2", bus.out_ad_valid, 1'b0);
    wait_drain(10);

    for (int v = 0; v < 5; v++) begin
      log_q.delete();
      drive(vecs[v].mask);
      #1;
      chk($sformatf("vec%0d_done", v), bus.in_ad_done, vecs[v].exp_done);
      tick();
      drive(4'b0000);
      wait_drain(20);
      chk($sformatf("vec%0d_n", v), log_q.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++)
        chk($sformatf("vec%0d_ord%0d", v, k), log_at(k), vecs[v].order[k]);
    end

    // input 0 streams, input 3 joins once at cycle 3
    log_q.delete();
    for (int c = 0; c < 10; c++) begin
      drive((c == 3) ? 4'b1001 : 4'b0001);
      tick();
    end
    drive(4'b0000);
    wait_drain(20);
    chk("t3_n", log_q.size(), 11);
    chk("t3_pos", log_at(4), 3);
    chk("t3_prev", log_at(3), 0);

    // backpressure: DEPTH in FIFO + 1 in output register
    log_q.delete();
    bus.out_ad_done = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010);
      #1;
      if (bus.in_ad_done[1]) acc++;
      if (c == 19) chk("t4_done_low", bus.in_ad_done[1], 1'b0);
      tick();
      if (c == 2 || c == 19)
        chk($sformatf("t4_addr%0d", c), bus.out_ad_addr, mk_addr(1, tag - c - 1));
    end
    chk("t4_accepts", acc, 5);
    drive(4'b0000);
    bus.out_ad_done = 1'b1;
    wait_drain(20);

    // reset with 3 entries buffered
    bus.out_ad_done = 1'b0;
    drive(4'b0111);
    tick();
    drive(4'b0000);
    tick();
    chk("t5_pre_valid", bus.out_ad_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", bus.out_ad_valid, 1'b0);
    drive(4'b1111);
    #1;
    chk("t5_done", bus.in_ad_done, 4'b0000);
    sb.delete();
    tick();
    drive(4'b0000);
    rst_n = 1'b1;
    bus.out_ad_done = 1'b1;
    repeat (5) tick();
    chk("t5_no_stale", bus.out_ad_valid, 1'b0);
    log_q.delete();
    drive(4'b1111);
    #1;
    chk("t5_empty", bus.in_ad_done, 4'b1111);
    tick();
    drive(4'b0000);
    wait_drain(20);
    chk("t5_n", log_q.size(), 4);

    // saturated ages tie: lowest index wins despite older input 3
    log_q.delete();
    bus.out_ad_done = 1'b0;
    drive(4'b0100);
    tick();
    drive(4'b0000);
    tick();
    drive(4'b1000);
    tick();
    drive(4'b0000);
    repeat (5) tick();
    drive(4'b0001);
    tick();
    drive(4'b0000);
    repeat (300) tick();
    bus.out_ad_done = 1'b1;
    wait_drain(20);
    chk("sat_n", log_q.size(), 3);
    chk("sat_0", log_at(0), 2);
    chk("sat_1", log_at(1), 0);
    chk("sat_2", log_at(2), 3);

`ifdef ABRAM_ARB_STATS_EN
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("st_clr", grant_count[0], 32'd0);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0001);
      tick();
      drive(4'b0000);
      tick();
    end
    wait_drain(20);
    chk("st_five", grant_count[0], 32'd5);
    drive(4'b0001);
    tick();
    drive(4'b0000);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("st_clr_wins", grant_count[0], 32'd0);
    wait_drain(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
